stack_ram_responder: RTL and testbench
======================================

Name: stack_ram_responder

Overview:
- Memory-side responder for the CPU's level start/done RAM protocol.
- Serves one read port (stack/instruction fetch) and one write port (stack store / register spill) from one on-chip word-addressed single-port RAM.
- Moves one 16-bit word per cycle; packs and unpacks 256-bit lines MSB-first, matching the CPU register-file layout.

Parameters:
- ADDR_W, 10, word-address width; RAM depth = 2**ADDR_W 16-bit words.
- MAX_WORDS, 16, maximum words per request (256-bit line).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  one clock; reset is asynchronous and active-low.
- rd_start  in  1  read request; held high by the CPU until rd_done is seen.
- rd_address  in  16  first word address; only low ADDR_W bits are used.
- rd_bytes  in  16  word count of the read.
- rd_q  out  256  read line; word k is at [255-16k -: 16].
- rd_done  out  1  read complete.
- wr_start  in  1  write request; same handshake as rd_start.
- wr_address  in  16  first word address.
- wr_bytes  in  16  word count of the write.
- wr_data  in  256  write line; word k is taken from [255-16k -: 16].
- wr_done  out  1  write complete.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset, async on reset_n low:
  - state goes to IDLE.
  - rd_q=0, rd_done=0, wr_done=0, busy=0.
  - Word counter and address register are cleared.
  - RAM contents are not cleared. Words already written persist, including those of an aborted write.
- Count rule: N = min(bytes, MAX_WORDS). N=0 performs no RAM access and still completes.
- Address rule: word k uses address (addr + k) mod 2**ADDR_W. Wrap-around is silent.
- Request, address, count and wr_data are latched on the edge that samples start in IDLE. Later input changes are ignored.
- Arbitration: if rd_start and wr_start are both high in IDLE, the write is served first. The read stays pending and is served after the write's handshake closes.
- States: IDLE, WR, RD_ISSUE, RD_DRAIN, DONE_WR, DONE_RD.
- IDLE:
  - wr_start -> WR.
  - else rd_start -> RD_ISSUE, with rd_q cleared to 0 on that edge.
  - N=0 goes directly to the matching DONE state.
- WR:
  - One word is written per edge, k=0..N-1.
  - On the edge writing word N-1: wr_done <= 1, go to DONE_WR.
  - Latency: wr_done is visible N cycles after the start-sampling edge.
- RD_ISSUE:
  - Address k is presented on edges 1..N after sampling.
  - The RAM is synchronous with 1-cycle read latency.
  - After address N-1 -> RD_DRAIN.
- RD_DRAIN:
  - Captures the final word into rd_q, sets rd_done <= 1, goes to DONE_RD.
  - Captured words land in their slots; unused slots stay 0.
  - Latency: rd_done is visible N+1 cycles after sampling (N>=1). For N=0, done is visible 1 cycle after sampling.
- DONE_x:
  - done stays high while the matching start stays high.
  - Once start is sampled low, done <= 0 and the FSM goes to IDLE.
  - If start was already low, done is high for exactly one cycle.
  - A new request is sampled no earlier than the cycle after done falls.
- rd_q holds its value after completion until the next read starts. The CPU samples rd_q when it sees rd_done.
- If start drops mid-operation, the transfer still completes. done then pulses for one cycle.
- Each request port is served only when its own start is high. No same-port back-to-back acceptance without done dropping.
- Reset mid-operation aborts immediately. No done is generated.

Decomposition:
- Shared package (`stack_ram_pkg`) holds:
  - WORD_W=16, LINE_W=256, MAX_WORDS=16.
  - The state enum.
  - A word-count clamp function.
- One sub-module, stack_ram_sp:
  - Single-port synchronous RAM: clock, we, addr[ADDR_W], din[16], dout[16].
  - No reset on the array; 1-cycle registered read.

Test Plan:
- Write 1 word 0xBEEF at address 5, then read 1 word at 5 -> wr_done 1 cycle after sampling; rd_done 2 cycles after sampling; rd_q[255:240]=0xBEEF, rest 0.
- Write a 16-word line of words 0x0000..0x000F at address 100, then read 16 at 100 -> rd_q word k = k. wr_done latency 16 cycles, rd_done latency 17 cycles.
- Write 4 words 0xA1..0xA4 at address 1022 (ADDR_W=10), then read 2 at 0 -> rd_q[255:224] = {0x00A3, 0x00A4}, confirming wrap.
- rd_start and wr_start high together, same address 7, wr word 0x1234 -> write done first; after wr_start drops, the read returns 0x1234.
- Count 0 -> done 1 cycle after sampling, memory unchanged. Count 20 -> behaves as 16, and address+16 is untouched.
- Assert reset_n low mid-way through an 8-word write -> outputs go to 0 immediately. A read afterwards shows the words written before reset and prior contents elsewhere.

Source files
------------

// File: rtl/stack_ram_pkg.sv
// Shared types, sizes and helpers for the stack RAM responder.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package stack_ram_pkg;

   localparam int WORD_W    = 16;
   localparam int LINE_W    = 256;
   localparam int MAX_WORDS = 16;
   // Counter holds 0..MAX_WORDS inclusive.
   localparam int CNT_W     = 5;
   // Slot index within a line, 0..MAX_WORDS-1.
   localparam int SLOT_W    = 4;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_WR       = 3'd1;
   localparam state_t ST_RD_ISSUE = 3'd2;
   localparam state_t ST_RD_DRAIN = 3'd3;
   localparam state_t ST_DONE_WR  = 3'd4;
   localparam state_t ST_DONE_RD  = 3'd5;

   // Requested word count limited to one line.
   function automatic logic [CNT_W-1:0] clamp_words(input logic [15:0] bytes, input int limit);
      if (int'(bytes) > limit) return CNT_W'(limit);
      return CNT_W'(bytes);
   endfunction

endpackage

// File: rtl/stack_ram_sp.sv
// Single-port synchronous word RAM, no reset on the array.
// Latency: write and read both take effect on the clock edge; dout is registered (1 cycle).
// Backpressure: none; one access per cycle, read returns the pre-write value on a collision.
module stack_ram_sp #(
   parameter int ADDR_W = 10
) (
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [15:0]       din,
   output logic [15:0]       dout
);

   logic [15:0] mem [0:(2**ADDR_W)-1];

   // Write port and registered read share the same address each cycle.
   always_ff @(posedge clock) begin
      if (we) mem[addr] <= din;
      dout <= mem[addr];
   end

endmodule

// File: rtl/stack_ram_responder.sv
// Memory-side responder for the CPU start/done RAM protocol: one word per cycle, 256-bit lines MSB-first.
// Latency: write done N cycles after the start-sampling edge, read done N+1 cycles (N=0: 1 cycle).
// Backpressure: done is held while start stays high; a new request is accepted only from IDLE.
module stack_ram_responder #(
   parameter int ADDR_W    = 10,
   parameter int MAX_WORDS = 16
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         rd_start,
   input  logic [15:0]  rd_address,
   input  logic [15:0]  rd_bytes,
   output logic [255:0] rd_q,
   output logic         rd_done,
   input  logic         wr_start,
   input  logic [15:0]  wr_address,
   input  logic [15:0]  wr_bytes,
   input  logic [255:0] wr_data,
   output logic         wr_done,
   output logic         busy
);
   import stack_ram_pkg::*;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  n_words;
   logic [ADDR_W-1:0] addr;
   logic [LINE_W-1:0] wr_line;
   logic [CNT_W-1:0]  n_wr;
   logic [CNT_W-1:0]  n_rd;
   logic [SLOT_W-1:0] slot;
   logic              ram_we;
   logic [WORD_W-1:0] ram_din;
   logic [WORD_W-1:0] ram_dout;

   assign n_wr    = clamp_words(wr_bytes, MAX_WORDS);
   assign n_rd    = clamp_words(rd_bytes, MAX_WORDS);
   // Data returned this cycle belongs to the address presented one cycle earlier.
   assign slot    = cnt[SLOT_W-1:0] - SLOT_W'(1);
   assign ram_we  = (state == ST_WR);
   // The write line is shifted left each word, so the next word is always on top.
   assign ram_din = wr_line[LINE_W-1 -: WORD_W];
   assign busy    = (state != ST_IDLE);

   stack_ram_sp #(.ADDR_W(ADDR_W)) u_ram (
      .clock (clock),
      .we    (ram_we),
      .addr  (addr),
      .din   (ram_din),
      .dout  (ram_dout)
   );

   // Request sequencing, address/count tracking and line pack/unpack.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         n_words <= '0;
         addr    <= '0;
         wr_line <= '0;
         rd_q    <= '0;
         rd_done <= 1'b0;
         wr_done <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               // Write wins when both ports request together; the read simply stays pending.
               if (wr_start) begin
                  n_words <= n_wr;
                  addr    <= wr_address[ADDR_W-1:0];
                  wr_line <= wr_data;
                  state   <= (n_wr == '0) ? ST_DONE_WR : ST_WR;
               end else if (rd_start) begin
                  n_words <= n_rd;
                  addr    <= rd_address[ADDR_W-1:0];
                  rd_q    <= '0;
                  state   <= (n_rd == '0) ? ST_DONE_RD : ST_RD_ISSUE;
               end
            end
            ST_WR: begin
               addr    <= addr + ADDR_W'(1);
               cnt     <= cnt + CNT_W'(1);
               wr_line <= wr_line << WORD_W;
               if (cnt == n_words - CNT_W'(1)) begin
                  wr_done <= 1'b1;
                  state   <= ST_DONE_WR;
               end
            end
            ST_RD_ISSUE: begin
               addr <= addr + ADDR_W'(1);
               cnt  <= cnt + CNT_W'(1);
               if (cnt != '0) rd_q[(LINE_W - 1) - WORD_W * int'(slot) -: WORD_W] <= ram_dout;
               if (cnt == n_words - CNT_W'(1)) state <= ST_RD_DRAIN;
            end
            ST_RD_DRAIN: begin
               rd_q[(LINE_W - 1) - WORD_W * int'(slot) -: WORD_W] <= ram_dout;
               rd_done <= 1'b1;
               state   <= ST_DONE_RD;
            end
            // A zero-length request arrives here with done still low and raises it one cycle later.
            ST_DONE_WR: begin
               if (!wr_done) begin
                  wr_done <= 1'b1;
               end else if (!wr_start) begin
                  wr_done <= 1'b0;
                  state   <= ST_IDLE;
               end
            end
            ST_DONE_RD: begin
               if (!rd_done) begin
                  rd_done <= 1'b1;
               end else if (!rd_start) begin
                  rd_done <= 1'b0;
                  state   <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_ram_responder.sv
// Directed test bench for stack_ram_responder.
// Latency: measured in clock edges after the start-sampling edge.
// Backpressure: start is held until done is seen, then dropped.
module tb_stack_ram_responder;

   logic         clock = 1'b0;
   logic         reset_n;
   logic         rd_start;
   logic [15:0]  rd_address;
   logic [15:0]  rd_bytes;
   logic [255:0] rd_q;
   logic         rd_done;
   logic         wr_start;
   logic [15:0]  wr_address;
   logic [15:0]  wr_bytes;
   logic [255:0] wr_data;
   logic         wr_done;
   logic         busy;

   int passed = 0;
   int total  = 0;

   stack_ram_responder #(.ADDR_W(10), .MAX_WORDS(16)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .rd_start   (rd_start),
      .rd_address (rd_address),
      .rd_bytes   (rd_bytes),
      .rd_q       (rd_q),
      .rd_done    (rd_done),
      .wr_start   (wr_start),
      .wr_address (wr_address),
      .wr_bytes   (wr_bytes),
      .wr_data    (wr_data),
      .wr_done    (wr_done),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
      $fatal(1);
   end

   task automatic wait_idle();
      int c = 0;
      while (busy !== 1'b0 && c < 20) begin
         @(posedge clock); #1;
         c++;
      end
      total++;
      if (busy !== 1'b0) $display("FAIL idle_timeout: busy=%b required 0", busy);
      else passed++;
   endtask

   task automatic do_write(input logic [15:0] a, input logic [15:0] n, input logic [255:0] d,
                           output int lat);
      wr_address = a; wr_bytes = n; wr_data = d; wr_start = 1'b1;
      @(posedge clock); #1;
      wr_data = ~d; wr_address = a + 16'd3; wr_bytes = 16'd2;
      lat = 0;
      while (wr_done !== 1'b1 && lat < 40) begin
         @(posedge clock); #1;
         lat++;
      end
      if (wr_done !== 1'b1) lat = -1;
      wr_start = 1'b0;
      wait_idle();
   endtask

   task automatic do_read(input logic [15:0] a, input logic [15:0] n,
                          output int lat, output logic [255:0] q);
      rd_address = a; rd_bytes = n; rd_start = 1'b1;
      @(posedge clock); #1;
      rd_address = a + 16'd5; rd_bytes = 16'd1;
      lat = 0;
      while (rd_done !== 1'b1 && lat < 40) begin
         @(posedge clock); #1;
         lat++;
      end
      if (rd_done !== 1'b1) lat = -1;
      q = rd_q;
      rd_start = 1'b0;
      wait_idle();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      rd_start = 1'b0; rd_address = '0; rd_bytes = '0;
      wr_start = 1'b0; wr_address = '0; wr_bytes = '0; wr_data = '0;
      repeat (2) @(posedge clock);
      #1;
      total++;
      if ({busy, rd_done, wr_done} !== 3'b000) $display("FAIL reset_flags: busy/rd_done/wr_done=%b required 000", {busy, rd_done, wr_done});
      else passed++;
      total++;
      if (rd_q !== 256'h0) $display("FAIL reset_rd_q: got %h required 0", rd_q);
      else passed++;
      reset_n = 1'b1;
      @(posedge clock); #1;
      total++;
      if (busy !== 1'b0) $display("FAIL reset_release_busy: got %b required 0", busy);
      else passed++;
   endtask

   task automatic test_single_word();
      int lat;
      logic [255:0] q;
      do_write(16'd5, 16'd1, {16'hBEEF, 240'h0}, lat);
      total++;
      if (lat !== 1) $display("FAIL single_wr_latency: got %0d required 1", lat);
      else passed++;
      do_read(16'd5, 16'd1, lat, q);
      total++;
      if (lat !== 2) $display("FAIL single_rd_latency: got %0d required 2", lat);
      else passed++;
      total++;
      if (q !== {16'hBEEF, 240'h0}) $display("FAIL single_rd_q: got %h required %h", q, {16'hBEEF, 240'h0});
      else passed++;
   endtask

   task automatic test_full_line();
      int lat;
      logic [255:0] q;
      logic [255:0] line;
      for (int k = 0; k < 16; k++) line[255 - 16*k -: 16] = 16'(k);
      do_write(16'd100, 16'd16, line, lat);
      total++;
      if (lat !== 16) $display("FAIL line_wr_latency: got %0d required 16", lat);
      else passed++;
      do_read(16'd100, 16'd16, lat, q);
      total++;
      if (lat !== 17) $display("FAIL line_rd_latency: got %0d required 17", lat);
      else passed++;
      total++;
      if (q !== line) $display("FAIL line_rd_q: got %h required %h", q, line);
      else passed++;
   endtask

   task automatic test_wrap();
      int lat;
      logic [255:0] q;
      logic [255:0] d = '0;
      d[255:192] = 64'h00A1_00A2_00A3_00A4;
      do_write(16'd1022, 16'd4, d, lat);
      total++;
      if (lat !== 4) $display("FAIL wrap_wr_latency: got %0d required 4", lat);
      else passed++;
      do_read(16'd0, 16'd2, lat, q);
      total++;
      if (q[255:224] !== 32'h00A3_00A4) $display("FAIL wrap_rd_words: got %h required 00a300a4", q[255:224]);
      else passed++;
      total++;
      if (q[223:0] !== 224'h0) $display("FAIL wrap_rd_unused: got %h required 0", q[223:0]);
      else passed++;
   endtask

   task automatic test_arbitration();
      int c;
      wr_address = 16'd7; wr_bytes = 16'd1; wr_data = {16'h1234, 240'h0};
      rd_address = 16'd7; rd_bytes = 16'd1;
      wr_start = 1'b1; rd_start = 1'b1;
      @(posedge clock); #1;
      c = 0;
      while (wr_done !== 1'b1 && rd_done !== 1'b1 && c < 40) begin
         @(posedge clock); #1;
         c++;
      end
      total++;
      if ({wr_done, rd_done} !== 2'b10) $display("FAIL arb_write_first: wr_done/rd_done=%b required 10", {wr_done, rd_done});
      else passed++;
      @(posedge clock); #1;
      total++;
      if ({wr_done, rd_done} !== 2'b10) $display("FAIL arb_done_hold: wr_done/rd_done=%b required 10", {wr_done, rd_done});
      else passed++;
      wr_start = 1'b0;
      c = 0;
      while (rd_done !== 1'b1 && c < 40) begin
         @(posedge clock); #1;
         c++;
      end
      total++;
      if (rd_done !== 1'b1) $display("FAIL arb_read_done: got %b required 1", rd_done);
      else passed++;
      total++;
      if (rd_q[255:240] !== 16'h1234) $display("FAIL arb_read_data: got %h required 1234", rd_q[255:240]);
      else passed++;
      rd_start = 1'b0;
      wait_idle();
   endtask

   task automatic test_count_limits();
      int lat;
      logic [255:0] q;
      logic [255:0] line;
      do_write(16'd5, 16'd0, {256{1'b1}}, lat);
      total++;
      if (lat !== 1) $display("FAIL zero_wr_latency: got %0d required 1", lat);
      else passed++;
      do_read(16'hFC05, 16'd1, lat, q);
      total++;
      if (q[255:240] !== 16'hBEEF) $display("FAIL zero_wr_untouched: got %h required beef", q[255:240]);
      else passed++;
      do_read(16'd5, 16'd0, lat, q);
      total++;
      if (lat !== 1) $display("FAIL zero_rd_latency: got %0d required 1", lat);
      else passed++;
      total++;
      if (q !== 256'h0) $display("FAIL zero_rd_q: got %h required 0", q);
      else passed++;
      do_write(16'd316, 16'd1, {16'h7777, 240'h0}, lat);
      for (int k = 0; k < 16; k++) line[255 - 16*k -: 16] = 16'h3000 + 16'(k);
      do_write(16'd300, 16'd20, line, lat);
      total++;
      if (lat !== 16) $display("FAIL clamp_wr_latency: got %0d required 16", lat);
      else passed++;
      do_read(16'd316, 16'd1, lat, q);
      total++;
      if (q[255:240] !== 16'h7777) $display("FAIL clamp_beyond_line: got %h required 7777", q[255:240]);
      else passed++;
      do_read(16'd300, 16'd20, lat, q);
      total++;
      if (lat !== 17) $display("FAIL clamp_rd_latency: got %0d required 17", lat);
      else passed++;
      total++;
      if (q !== line) $display("FAIL clamp_rd_q: got %h required %h", q, line);
      else passed++;
   endtask

   task automatic test_start_drop();
      int c;
      wr_address = 16'd400; wr_bytes = 16'd3; wr_data = {48'h0AAA_0BBB_0CCC, 208'h0};
      wr_start = 1'b1;
      @(posedge clock); #1;
      wr_start = 1'b0;
      c = 0;
      while (wr_done !== 1'b1 && c < 40) begin
         @(posedge clock); #1;
         c++;
      end
      total++;
      if (c !== 3) $display("FAIL drop_wr_latency: got %0d required 3", c);
      else passed++;
      @(posedge clock); #1;
      total++;
      if ({wr_done, busy} !== 2'b00) $display("FAIL drop_done_pulse: wr_done/busy=%b required 00", {wr_done, busy});
      else passed++;
   endtask

   task automatic test_reset_mid_write();
      int lat;
      logic [255:0] q;
      logic [255:0] line;
      logic [255:0] exp;
      for (int k = 0; k < 8; k++) line[255 - 16*k -: 16] = 16'h5000 + 16'(k);
      line[127:0] = '0;
      do_write(16'd200, 16'd8, line, lat);
      for (int k = 0; k < 8; k++) line[255 - 16*k -: 16] = 16'h6000 + 16'(k);
      wr_address = 16'd200; wr_bytes = 16'd8; wr_data = line; wr_start = 1'b1;
      @(posedge clock); #1;
      repeat (3) @(posedge clock);
      #1;
      reset_n = 1'b0;
      #1;
      total++;
      if ({wr_done, rd_done, busy} !== 3'b000) $display("FAIL midreset_flags: wr_done/rd_done/busy=%b required 000", {wr_done, rd_done, busy});
      else passed++;
      total++;
      if (rd_q !== 256'h0) $display("FAIL midreset_rd_q: got %h required 0", rd_q);
      else passed++;
      wr_start = 1'b0;
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;
      exp = '0;
      for (int k = 0; k < 8; k++) exp[255 - 16*k -: 16] = (k < 3) ? 16'h6000 + 16'(k) : 16'h5000 + 16'(k);
      do_read(16'd200, 16'd8, lat, q);
      total++;
      if (q !== exp) $display("FAIL midreset_contents: got %h required %h", q, exp);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_full_line();
      test_wrap();
      test_arbitration();
      test_count_limits();
      test_start_drop();
      test_reset_mid_write();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
